// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: hazard sources from ID/EX/MEM and caches, latch controls back to the pipeline.
interface hazard_ctrl_if;
   localparam int unsigned REG_W = 5;

   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             id_useRt;
   logic [REG_W-1:0] ex_rd;
   logic             ex_rfWEN;
   logic             ex_dREN;
   logic             mem_dREN;
   logic             mem_dWEN;
   logic             dhit;
   logic             ihit;
   logic             mem_redirect;
   logic             mem_halt;

   logic             pc_en;
   logic             ifid_en;
   logic             idex_en;
   logic             exmem_en;
   logic             memwb_en;
   logic             ifid_flush;
   logic             idex_flush;
   logic             exmem_flush;

   // datapath side: presents hazard sources, consumes latch controls
   modport master (
      output id_rs, id_rt, id_useRt, ex_rd, ex_rfWEN, ex_dREN,
             mem_dREN, mem_dWEN, dhit, ihit, mem_redirect, mem_halt,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush
   );

   // controller side
   modport slave (
      input  id_rs, id_rt, id_useRt, ex_rd, ex_rfWEN, ex_dREN,
             mem_dREN, mem_dWEN, dhit, ihit, mem_redirect, mem_halt,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: resolves hazards forwarding cannot cover and counts stalls/redirects.
module hazard_ctrl #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST,
   hazard_ctrl_if.slave     hz,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_DWAIT = 2'd1,
      S_HALT  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic memreq_c, loaduse_c;
   logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
   logic ifid_flush_c, idex_flush_c, exmem_flush_c, halted_c;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   // hazard detection terms
   always_comb begin
      memreq_c  = hz.mem_dREN | hz.mem_dWEN;
      loaduse_c = hz.ex_dREN & hz.ex_rfWEN & (hz.ex_rd != '0) &
                  ((hz.ex_rd == hz.id_rs) | (hz.id_useRt & (hz.ex_rd == hz.id_rt)));
   end

   // next state, latch controls and counter updates
   always_comb begin
      state_d       = state_q;
      stall_cnt_d   = stall_cnt_q;
      flush_cnt_d   = flush_cnt_q;
      pc_en_c       = 1'b0;
      ifid_en_c     = 1'b0;
      idex_en_c     = 1'b0;
      exmem_en_c    = 1'b0;
      memwb_en_c    = 1'b0;
      ifid_flush_c  = 1'b0;
      idex_flush_c  = 1'b0;
      exmem_flush_c = 1'b0;
      halted_c      = 1'b0;

      if (RST) begin
         ifid_flush_c  = 1'b1;
         idex_flush_c  = 1'b1;
         exmem_flush_c = 1'b1;
         state_d       = S_RUN;
         stall_cnt_d   = '0;
         flush_cnt_d   = '0;
      end else begin
         unique case (state_q)
            S_HALT: halted_c = 1'b1;
            S_RUN, S_DWAIT: begin
               // a DWAIT cycle with dhit is a full RUN cycle, so no cycle is lost on the hit
               if ((state_q == S_RUN) || hz.dhit) begin
                  state_d = S_RUN;
                  if (hz.mem_halt) begin
                     memwb_en_c = 1'b1;
                     state_d    = S_HALT;
                  end else if (memreq_c && !hz.dhit) begin
                     state_d = S_DWAIT;
                  end else if (hz.mem_redirect) begin
                     pc_en_c       = 1'b1;
                     ifid_en_c     = 1'b1;
                     idex_en_c     = 1'b1;
                     exmem_en_c    = 1'b1;
                     memwb_en_c    = 1'b1;
                     ifid_flush_c  = 1'b1;
                     idex_flush_c  = 1'b1;
                     exmem_flush_c = 1'b1;
                     flush_cnt_d   = sat_inc(flush_cnt_q);
                  end else if (loaduse_c) begin
                     idex_en_c    = 1'b1;
                     exmem_en_c   = 1'b1;
                     memwb_en_c   = 1'b1;
                     idex_flush_c = 1'b1;
                  end else if (!hz.ihit) begin
                     ifid_en_c    = 1'b1;
                     idex_en_c    = 1'b1;
                     exmem_en_c   = 1'b1;
                     memwb_en_c   = 1'b1;
                     ifid_flush_c = 1'b1;
                  end else begin
                     pc_en_c    = 1'b1;
                     ifid_en_c  = 1'b1;
                     idex_en_c  = 1'b1;
                     exmem_en_c = 1'b1;
                     memwb_en_c = 1'b1;
                  end
               end
               if (!pc_en_c) begin
                  stall_cnt_d = sat_inc(stall_cnt_q);
               end
            end
            default: state_d = S_RUN;
         endcase
      end
   end

   // state and counter registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= S_RUN;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hz.pc_en       = pc_en_c;
   assign hz.ifid_en     = ifid_en_c;
   assign hz.idex_en     = idex_en_c;
   assign hz.exmem_en    = exmem_en_c;
   assign hz.memwb_en    = memwb_en_c;
   assign hz.ifid_flush  = ifid_flush_c;
   assign hz.idex_flush  = idex_flush_c;
   assign hz.exmem_flush = exmem_flush_c;
   assign halted         = halted_c;
   assign stall_cnt      = stall_cnt_q;
   assign flush_cnt      = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table, corner-case sequences and random stimulus against a reference model.
module tb_hazard_ctrl;
   typedef struct packed {
      logic [4:0] id_rs;
      logic [4:0] id_rt;
      logic       id_useRt;
      logic [4:0] ex_rd;
      logic       ex_rfWEN;
      logic       ex_dREN;
      logic       mem_dREN;
      logic       mem_dWEN;
      logic       dhit;
      logic       ihit;
      logic       mem_redirect;
      logic       mem_halt;
   } in_t;

   // exp = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush}
   typedef struct {
      string      name;
      in_t        i;
      logic [7:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   in_t  vin;
   int   n_tests = 0;
   int   n_fail  = 0;

   hazard_ctrl_if hz32();
   hazard_ctrl_if hz3();

   logic        halted32, halted3;
   logic [31:0] stall32, flush32;
   logic [2:0]  stall3, flush3;
   logic [8:0]  o32, o3;

   hazard_ctrl #(.CNT_W(32)) dut (
      .CLK(clk), .RST(rst), .hz(hz32.slave),
      .halted(halted32), .stall_cnt(stall32), .flush_cnt(flush32)
   );

   hazard_ctrl #(.CNT_W(3)) dut_s (
      .CLK(clk), .RST(rst), .hz(hz3.slave),
      .halted(halted3), .stall_cnt(stall3), .flush_cnt(flush3)
   );

   assign {hz32.id_rs, hz32.id_rt, hz32.id_useRt, hz32.ex_rd, hz32.ex_rfWEN, hz32.ex_dREN,
           hz32.mem_dREN, hz32.mem_dWEN, hz32.dhit, hz32.ihit, hz32.mem_redirect, hz32.mem_halt} = vin;
   assign {hz3.id_rs, hz3.id_rt, hz3.id_useRt, hz3.ex_rd, hz3.ex_rfWEN, hz3.ex_dREN,
           hz3.mem_dREN, hz3.mem_dWEN, hz3.dhit, hz3.ihit, hz3.mem_redirect, hz3.mem_halt} = vin;

   assign o32 = {hz32.pc_en, hz32.ifid_en, hz32.idex_en, hz32.exmem_en, hz32.memwb_en,
                 hz32.ifid_flush, hz32.idex_flush, hz32.exmem_flush, halted32};
   assign o3  = {hz3.pc_en, hz3.ifid_en, hz3.idex_en, hz3.exmem_en, hz3.memwb_en,
                 hz3.ifid_flush, hz3.idex_flush, hz3.exmem_flush, halted3};

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt, input bit use_rt,
                              input logic [4:0] rd, input bit wen, input bit dren,
                              input bit mrd, input bit mwr, input bit dh, input bit ih,
                              input bit redir, input bit hlt);
      in_t r;
      r.id_rs = rs;   r.id_rt = rt;       r.id_useRt = use_rt; r.ex_rd = rd;
      r.ex_rfWEN = wen; r.ex_dREN = dren; r.mem_dREN = mrd;    r.mem_dWEN = mwr;
      r.dhit = dh;    r.ihit = ih;        r.mem_redirect = redir; r.mem_halt = hlt;
      return r;
   endfunction

   function automatic in_t idle();
      return mk(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
   endfunction

   function automatic in_t rnd_in();
      in_t r;
      r.id_rs        = 5'($urandom_range(0, 3));
      r.id_rt        = 5'($urandom_range(0, 3));
      r.id_useRt     = 1'($urandom_range(0, 1));
      r.ex_rd        = 5'($urandom_range(0, 3));
      r.ex_rfWEN     = 1'($urandom_range(0, 1));
      r.ex_dREN      = 1'($urandom_range(0, 1));
      r.mem_dREN     = 1'(($urandom % 4) == 0);
      r.mem_dWEN     = 1'(($urandom % 6) == 0);
      r.dhit         = 1'(($urandom % 3) != 0);
      r.ihit         = 1'(($urandom % 4) != 0);
      r.mem_redirect = 1'(($urandom % 6) == 0);
      r.mem_halt     = 1'(($urandom % 40) == 0);
      return r;
   endfunction

   function automatic longint sat3(input longint v);
      return (v > 64'd7) ? 64'd7 : v;
   endfunction

   // Reference: the model tracks only "waiting on dcache" and "halted"; each cycle's outcome is
   // picked from the hazard rules in priority order.
   bit     m_wait = 1'b0, m_halt = 1'b0, chk_en = 1'b0;
   longint m_stall = 0, m_flush = 0;
   bit     n_wait, n_halt, inc_s, inc_f;
   logic [8:0] m_o;

   task automatic model(input in_t i, input logic r, input bit waiting, input bit hlt,
                        output logic [8:0] o, output bit nw, output bit nh,
                        output bit is, output bit ifl);
      bit memreq, lu;
      nw = waiting; nh = hlt; is = 1'b0; ifl = 1'b0;
      memreq = i.mem_dREN | i.mem_dWEN;
      lu = i.ex_dREN && i.ex_rfWEN && (i.ex_rd != 5'd0) &&
           ((i.ex_rd == i.id_rs) || (i.id_useRt && (i.ex_rd == i.id_rt)));
      if (r) begin
         o = 9'b00000_111_0; nw = 1'b0; nh = 1'b0;
      end else if (hlt) begin
         o = 9'b00000_000_1;
      end else if (waiting && !i.dhit) begin
         o = 9'b0; is = 1'b1;
      end else begin
         nw = 1'b0;
         if (i.mem_halt)               begin o = 9'b00001_000_0; nh = 1'b1; end
         else if (memreq && !i.dhit)   begin o = 9'b0; nw = 1'b1; end
         else if (i.mem_redirect)      begin o = 9'b11111_111_0; ifl = 1'b1; end
         else if (lu)                  o = 9'b00111_010_0;
         else if (!i.ihit)             o = 9'b01111_100_0;
         else                          o = 9'b11111_000_0;
         is = !o[8];
      end
   endtask

   // compare both instances against the model every cycle
   always @(negedge clk) begin
      if (chk_en) begin
         model(vin, rst, m_wait, m_halt, m_o, n_wait, n_halt, inc_s, inc_f);
         chk("bg_out32", o32, m_o);
         chk("bg_out3", o3, m_o);
         chk("bg_stall32", stall32, m_stall);
         chk("bg_stall3", stall3, sat3(m_stall));
         chk("bg_flush32", flush32, m_flush);
         chk("bg_flush3", flush3, sat3(m_flush));
      end
   end

   // advance the model on the clock edge
   always @(posedge clk) begin
      if (chk_en) begin
         m_wait = n_wait;
         m_halt = n_halt;
         if (rst) begin
            m_stall = 0;
            m_flush = 0;
         end else begin
            m_stall += longint'(inc_s);
            m_flush += longint'(inc_f);
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      vin = idle();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      vec_t vecs[13];
      in_t  t;

      do_reset();
      chk_en = 1'b1;
      #1;
      chk("reset_out", o32, 9'b11111_000_0);
      chk("reset_stall", stall32, 0);
      chk("reset_flush", flush32, 0);

      vecs[0]  = '{"plain",          mk(1, 2, 1, 3, 1, 0, 0, 0, 1, 1, 0, 0), 8'b11111_000};
      vecs[1]  = '{"lu_rs",          mk(5, 2, 0, 5, 1, 1, 0, 0, 1, 1, 0, 0), 8'b00111_010};
      vecs[2]  = '{"lu_rd0",         mk(0, 2, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0), 8'b11111_000};
      vecs[3]  = '{"lu_rt",          mk(1, 7, 1, 7, 1, 1, 0, 0, 1, 1, 0, 0), 8'b00111_010};
      vecs[4]  = '{"rt_unused",      mk(1, 7, 0, 7, 1, 1, 0, 0, 1, 1, 0, 0), 8'b11111_000};
      vecs[5]  = '{"lu_nowen",       mk(5, 2, 0, 5, 0, 1, 0, 0, 1, 1, 0, 0), 8'b11111_000};
      vecs[6]  = '{"imiss",          mk(1, 2, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0), 8'b01111_100};
      vecs[7]  = '{"dmiss",          mk(1, 2, 0, 3, 0, 0, 1, 0, 0, 1, 0, 0), 8'b00000_000};
      vecs[8]  = '{"dwr_hit",        mk(1, 2, 0, 3, 0, 0, 0, 1, 1, 1, 0, 0), 8'b11111_000};
      vecs[9]  = '{"redir_lu_imiss", mk(5, 2, 0, 5, 1, 1, 0, 0, 1, 0, 1, 0), 8'b11111_111};
      vecs[10] = '{"halt_over_miss", mk(1, 2, 0, 3, 0, 0, 1, 0, 0, 1, 1, 1), 8'b00001_000};
      vecs[11] = '{"miss_over_redir",mk(1, 2, 0, 3, 0, 0, 0, 1, 0, 1, 1, 0), 8'b00000_000};
      vecs[12] = '{"lu_over_imiss",  mk(5, 2, 0, 5, 1, 1, 0, 0, 1, 0, 0, 0), 8'b00111_010};

      foreach (vecs[k]) begin
         do_reset();
         vin = vecs[k].i;
         #1;
         chk(vecs[k].name, o32[8:1], vecs[k].exp);
         chk({vecs[k].name, "_halted"}, o32[0], 1'b0);
      end

      // load-use: one bubble, then the load has moved on
      do_reset();
      vin = mk(5, 2, 0, 5, 1, 1, 0, 0, 1, 1, 0, 0);
      #1;
      chk("lu_seq_stall", o32, 9'b00111_010_0);
      tick();
      vin = idle();
      #1;
      chk("lu_seq_after", o32, 9'b11111_000_0);
      chk("lu_seq_cnt", stall32, 1);

      // dcache miss: entry cycle plus three DWAIT cycles, then the hit
      do_reset();
      vin = mk(1, 2, 0, 3, 0, 0, 1, 0, 0, 1, 0, 0);
      for (int c = 0; c < 4; c++) begin
         #1;
         chk("miss_frozen", o32, 9'b0);
         tick();
      end
      vin.dhit = 1'b1;
      #1;
      chk("miss_hit_cycle", o32, 9'b11111_000_0);
      tick();
      vin = idle();
      #1;
      chk("miss_cnt", stall32, 4);
      chk("miss_back_run", o32, 9'b11111_000_0);

      // redirect beats load-use and imiss
      do_reset();
      vin = mk(5, 2, 0, 5, 1, 1, 0, 0, 1, 0, 1, 0);
      #1;
      chk("redir_out", o32, 9'b11111_111_0);
      tick();
      vin = idle();
      #1;
      chk("redir_flush_cnt", flush32, 1);
      chk("redir_stall_cnt", stall32, 0);

      // halt: retire through MEM/WB, then frozen regardless of inputs until reset
      do_reset();
      vin = idle();
      vin.mem_halt = 1'b1;
      #1;
      chk("halt_retire", o32, 9'b00001_000_0);
      tick();
      for (int c = 0; c < 10; c++) begin
         t = rnd_in();
         t.mem_halt = 1'($urandom_range(0, 1));
         vin = t;
         #1;
         chk("halt_hold", o32, 9'b00000_000_1);
         tick();
      end
      chk("halt_stall_cnt", stall32, 1);
      do_reset();
      vin = idle();
      #1;
      chk("halt_reset_run", o32, 9'b11111_000_0);

      // reset in the middle of a dcache miss
      do_reset();
      vin = mk(1, 2, 0, 3, 0, 0, 1, 0, 0, 1, 0, 0);
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("rst_dwait_out", o32, 9'b00000_111_0);
      tick();
      rst = 1'b0;
      vin = idle();
      #1;
      chk("rst_dwait_run", o32, 9'b11111_000_0);
      chk("rst_dwait_cnt", stall32, 0);
      vin.ihit = 1'b0;
      #1;
      chk("rst_dwait_imiss", o32, 9'b01111_100_0);

      // saturation on the narrow instance
      do_reset();
      vin = idle();
      vin.ihit = 1'b0;
      for (int c = 0; c < 10; c++) tick();
      chk("sat_stall3", stall3, 3'd7);
      chk("sat_stall32", stall32, 10);
      tick();
      chk("sat_stall3_hold", stall3, 3'd7);

      // random traffic, occasional resets
      for (int c = 0; c < 3000; c++) begin
         vin = rnd_in();
         rst = 1'(($urandom % 25) == 0);
         tick();
      end
      rst = 1'b0;
      vin = idle();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
